reorder_buffer: RTL

- Circular in-order reorder buffer for the Tomasulo core.
- Allocates ROB tags at issue and captures results from the ex and ld CDBs.
- Commits one entry per cycle to the register file and LSB.
- Answers the register file's tag-readiness queries and raises the mispredict flush (jump_wrong_stall) when a wrongly predicted branch commits.

---
 rtl/reorder_buffer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: tag allocation, CDB capture, single commit per cycle, mispredict flush.
// Optional `ROB_HEAD_BYPASS_EN: a CDB hit on the not-done head commits on the same edge.
module reorder_buffer #(
  parameter int DEPTH = 16,
  parameter int IDXW  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        ID_alloc_flag,
  input  logic [4:0]  ID_alloc_rd,
  input  logic        ID_alloc_is_store,
  input  logic        ID_alloc_is_br,
  output logic        rob_full,
  output logic [31:0] rob_next_id,
  input  logic [31:0] rob_id1,
  input  logic [31:0] rob_id2,
  output logic        rob_id1_rdy,
  output logic        rob_id2_rdy,
  output logic [31:0] rob_id1_val,
  output logic [31:0] rob_id2_val,
  input  logic        ex_cdb_flag,
  input  logic [31:0] ex_cdb_rob_id,
  input  logic [31:0] ex_cdb_val,
  input  logic        ex_cdb_jump_wrong,
  input  logic [31:0] ex_cdb_jump_pc,
  input  logic        ld_cdb_flag,
  input  logic [31:0] ld_cdb_rob_id,
  input  logic [31:0] ld_cdb_val,
  output logic        ROB_cmt_flag,
  output logic [4:0]  ROB_cmt_rd,
  output logic [31:0] ROB_cmt_rob_id,
  output logic [31:0] ROB_cmt_val,
  output logic        ROB_cmt_store_flag,
  output logic        jump_wrong_stall,
  output logic [31:0] jump_pc
);

  typedef logic [IDXW-1:0] idx_t;
  typedef logic [IDXW:0]   cnt_t;

  logic [DEPTH-1:0] valid_q, done_q, store_q, br_q, jw_q;
  logic [4:0]       rd_q  [DEPTH];
  logic [31:0]      val_q [DEPTH];
  logic [31:0]      jpc_q [DEPTH];

  idx_t head_q, head_d, tail_q, tail_d;
  cnt_t count_q, count_d;

  logic        cmt_flag_q, cmt_store_q, stall_q;
  logic [4:0]  cmt_rd_q;
  logic [31:0] cmt_id_q, cmt_val_q, jpc_out_q;

  logic        alloc_ok, ex_hit, ld_hit, commit_ok, flush;
  idx_t        ex_idx, ld_idx, q1_idx, q2_idx;
  logic [31:0] cmt_val_c, cmt_jpc_c;
  logic        cmt_jw_c;

  // Tags are index+1; tag 0 and anything above DEPTH never name an entry.
  function automatic logic tag_ok(input logic [31:0] t);
    return (t != 32'd0) && (t <= 32'(DEPTH));
  endfunction

  function automatic idx_t tag_idx(input logic [31:0] t);
    return idx_t'(t - 32'd1);
  endfunction

  assign rob_full    = (count_q == cnt_t'(DEPTH));
  assign rob_next_id = 32'(tail_q) + 32'd1;

  // Commit/flush outputs are one-cycle pulses with no handshake; consumers
  // must take them the cycle they appear. rdy low forces them to 0.
  assign ROB_cmt_flag       = cmt_flag_q & rdy;
  assign ROB_cmt_store_flag = cmt_store_q & rdy;
  assign jump_wrong_stall   = stall_q & rdy;
  assign ROB_cmt_rd         = cmt_rd_q;
  assign ROB_cmt_rob_id     = cmt_id_q;
  assign ROB_cmt_val        = cmt_val_q;
  assign jump_pc            = jpc_out_q;

  always_comb begin
    ex_idx   = tag_idx(ex_cdb_rob_id);
    ld_idx   = tag_idx(ld_cdb_rob_id);
    ex_hit   = ex_cdb_flag & ~stall_q & tag_ok(ex_cdb_rob_id) & valid_q[ex_idx] & ~done_q[ex_idx];
    ld_hit   = ld_cdb_flag & ~stall_q & tag_ok(ld_cdb_rob_id) & valid_q[ld_idx] & ~done_q[ld_idx];
    alloc_ok = ID_alloc_flag & ~rob_full & ~stall_q;
`ifdef ROB_HEAD_BYPASS_EN
    commit_ok = valid_q[head_q] &
                (done_q[head_q] | (ex_hit & (ex_idx == head_q)) | (ld_hit & (ld_idx == head_q)));
    if (done_q[head_q]) begin
      cmt_val_c = val_q[head_q];
      cmt_jw_c  = jw_q[head_q];
      cmt_jpc_c = jpc_q[head_q];
    end else if (ex_hit & (ex_idx == head_q)) begin
      cmt_val_c = ex_cdb_val;
      cmt_jw_c  = ex_cdb_jump_wrong & br_q[head_q];
      cmt_jpc_c = ex_cdb_jump_pc;
    end else begin
      cmt_val_c = ld_cdb_val;
      cmt_jw_c  = 1'b0;
      cmt_jpc_c = 32'd0;
    end
`else
    commit_ok = valid_q[head_q] & done_q[head_q];
    cmt_val_c = val_q[head_q];
    cmt_jw_c  = jw_q[head_q];
    cmt_jpc_c = jpc_q[head_q];
`endif
    flush = commit_ok & cmt_jw_c;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (alloc_ok)  tail_d = tail_q + idx_t'(1);
      if (commit_ok) head_d = head_q + idx_t'(1);
      count_d = count_q + cnt_t'(alloc_ok) - cnt_t'(commit_ok);
    end
  end

  always_comb begin
    q1_idx      = tag_idx(rob_id1);
    q2_idx      = tag_idx(rob_id2);
    rob_id1_rdy = tag_ok(rob_id1) & valid_q[q1_idx] & done_q[q1_idx];
    rob_id2_rdy = tag_ok(rob_id2) & valid_q[q2_idx] & done_q[q2_idx];
    rob_id1_val = tag_ok(rob_id1) ? val_q[q1_idx] : 32'd0;
    rob_id2_val = tag_ok(rob_id2) ? val_q[q2_idx] : 32'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= '0;
      done_q      <= '0;
      store_q     <= '0;
      br_q        <= '0;
      jw_q        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]  <= '0;
        val_q[i] <= '0;
        jpc_q[i] <= '0;
      end
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      cmt_flag_q  <= 1'b0;
      cmt_store_q <= 1'b0;
      stall_q     <= 1'b0;
      cmt_rd_q    <= '0;
      cmt_id_q    <= '0;
      cmt_val_q   <= '0;
      jpc_out_q   <= '0;
    end else if (rdy) begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      cmt_flag_q  <= 1'b0;
      cmt_store_q <= 1'b0;
      stall_q     <= 1'b0;
      if (alloc_ok) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        jw_q[tail_q]    <= 1'b0;
        store_q[tail_q] <= ID_alloc_is_store;
        br_q[tail_q]    <= ID_alloc_is_br;
        rd_q[tail_q]    <= ID_alloc_rd;
      end
      if (ld_hit) begin
        done_q[ld_idx] <= 1'b1;
        val_q[ld_idx]  <= ld_cdb_val;
      end
      // Only branch entries can carry a mispredict.
      if (ex_hit) begin
        done_q[ex_idx] <= 1'b1;
        val_q[ex_idx]  <= ex_cdb_val;
        jw_q[ex_idx]   <= ex_cdb_jump_wrong & br_q[ex_idx];
        jpc_q[ex_idx]  <= ex_cdb_jump_pc;
      end
      if (commit_ok) begin
        valid_q[head_q] <= 1'b0;
        cmt_flag_q      <= ~store_q[head_q];
        cmt_store_q     <= store_q[head_q];
        cmt_rd_q        <= rd_q[head_q];
        cmt_id_q        <= 32'(head_q) + 32'd1;
        cmt_val_q       <= cmt_val_c;
      end
      if (flush) begin
        valid_q   <= '0;
        stall_q   <= 1'b1;
        jpc_out_q <= cmt_jpc_c;
      end
    end else begin
      // Frozen: state holds, but pulses are dropped so none repeats on wake-up.
      cmt_flag_q  <= 1'b0;
      cmt_store_q <= 1'b0;
      stall_q     <= 1'b0;
    end
  end

endmodule
